// File: rtl/mont_mult_r2.sv
// mont_mult_r2: bit-serial radix-2 Montgomery multiplier, result = A*B*2^-WIDTH mod M.
// One iteration per clock, then a single final conditional subtraction.
module mont_mult_r2 #(
    parameter int WIDTH = 1024,
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] M,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ITER  = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_reg_q, b_reg_d;
    logic [WIDTH-1:0] m_reg_q, m_reg_d;
    logic [WIDTH+1:0] s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH+2:0] t1, t2;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_reg_d  = b_reg_q;
        m_reg_d  = m_reg_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        // One spare bit above S keeps the sums exact even for out-of-range operands.
        t1 = {1'b0, s_q} + (a_sh_q[0] ? {3'b0, b_reg_q} : '0);
        t2 = t1 + (t1[0] ? {3'b0, m_reg_q} : '0);
        if (state_q == IDLE) begin
            busy_d = 1'b0;
            if (start) begin
                a_sh_d  = A;
                b_reg_d = B;
                m_reg_d = M;
                s_d     = '0;
                cnt_d   = CNT_W'(WIDTH);
                busy_d  = 1'b1;
                state_d = ITER;
            end
        end else if (state_q == ITER) begin
            s_d     = (WIDTH+2)'(t2 >> 1);
            a_sh_d  = a_sh_q >> 1;
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = (cnt_q == CNT_W'(1)) ? FINAL : ITER;
        end else if (state_q == FINAL) begin
            result_d = (s_q >= {2'b0, m_reg_q}) ? WIDTH'(s_q - {2'b0, m_reg_q}) : WIDTH'(s_q);
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_reg_q  <= '0;
            m_reg_q  <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_reg_q  <= b_reg_d;
            m_reg_q  <= m_reg_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule
